// File: rtl/screen_sequencer.sv
// Game-flow sequencer (logo, house select, trace, fade) driven by vsync frame ticks,
// plus the per-state pixel layer arbiter feeding the palette ROM index.
module screen_sequencer #(
    parameter int unsigned LOGO_FRAMES  = 180,
    parameter int unsigned TRACE_FRAMES = 1800,
    parameter int unsigned FADE_FRAMES  = 60,
    parameter logic [15:0] TARGET_MASK  = 16'hFFFF
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        vs,
    input  logic [3:0]  house_btn,
    input  logic [15:0] ir_in,
    input  logic        in_trace,
    input  logic        crest_here,
    input  logic        cursor_here,
    input  logic        traced_here,
    input  logic        fade_here,
    input  logic [7:0]  logo_idx,
    input  logic [7:0]  crest_idx,
    input  logic [7:0]  cursor_idx,
    input  logic [7:0]  box_idx,
    input  logic [7:0]  fade_idx,
    input  logic [7:0]  bg_idx,
    output logic [7:0]  pixel_index,
    output logic [1:0]  state,
    output logic [1:0]  house,
    output logic        house_valid,
    output logic        success,
    output logic        frame_tick
);

    typedef enum logic [1:0] {StLogo, StSelect, StTrace, StFade} state_e;

    localparam logic [11:0] LogoLast  = 12'(LOGO_FRAMES - 1);
    localparam logic [11:0] TraceLast = 12'(TRACE_FRAMES - 1);
    localparam logic [11:0] FadeLast  = 12'(FADE_FRAMES - 1);

    state_e      state_q, state_d;
    logic [11:0] fcnt_q, fcnt_d;
    logic [1:0]  house_q, house_d;
    logic        house_valid_q, house_valid_d;
    logic        success_q, success_d;
    logic        vs_prev_q;
    logic        frame_tick_q;
    logic [7:0]  pixel_q, pixel_d;

    logic        btn_onehot;
    logic [1:0]  btn_enc;
    logic        trace_done;

    assign btn_onehot = (house_btn != 4'd0) && ((house_btn & (house_btn - 4'd1)) == 4'd0);
    assign trace_done = (ir_in & TARGET_MASK) == TARGET_MASK;

    always_comb begin
        btn_enc = 2'd0;
        case (house_btn)
            4'b0010: btn_enc = 2'd1;
            4'b0100: btn_enc = 2'd2;
            4'b1000: btn_enc = 2'd3;
            default: btn_enc = 2'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        house_d       = house_q;
        house_valid_d = house_valid_q;
        success_d     = success_q;
        unique case (state_q)
            StLogo: begin
                if (frame_tick_q && fcnt_q == LogoLast) state_d = StSelect;
            end
            StSelect: begin
                if (btn_onehot) begin
                    state_d       = StTrace;
                    house_d       = btn_enc;
                    house_valid_d = 1'b1;
                    success_d     = 1'b0;
                end
            end
            StTrace: begin
                // Completion takes priority over a coincident timeout.
                if (trace_done) begin
                    state_d   = StFade;
                    success_d = 1'b1;
                end else if (frame_tick_q && fcnt_q == TraceLast) begin
                    state_d   = StFade;
                    success_d = 1'b0;
                end
            end
            StFade: begin
                if (frame_tick_q && fcnt_q == FadeLast) begin
                    state_d       = StSelect;
                    house_valid_d = 1'b0;
                end
            end
            default: state_d = StLogo;
        endcase
        // A tick coinciding with a state change is dropped; the new state starts from zero.
        if (state_d != state_q) begin
            fcnt_d = 12'd0;
        end else if (frame_tick_q) begin
            fcnt_d = fcnt_q + 12'd1;
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    always_comb begin
        pixel_d = bg_idx;
        unique case (state_q)
            StLogo: begin
                if (in_trace) pixel_d = logo_idx;
            end
            StSelect: begin
                if (crest_here) pixel_d = crest_idx;
            end
            StTrace: begin
                if (crest_here)                    pixel_d = crest_idx;
                else if (in_trace && cursor_here)  pixel_d = cursor_idx;
                else if (in_trace && traced_here)  pixel_d = box_idx;
                else if (in_trace)                 pixel_d = 8'd0;
            end
            StFade: begin
                if (crest_here)                 pixel_d = crest_idx;
                else if (fade_here && !in_trace) pixel_d = fade_idx;
            end
            default: pixel_d = bg_idx;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q       <= StLogo;
            fcnt_q        <= 12'd0;
            house_q       <= 2'd0;
            house_valid_q <= 1'b0;
            success_q     <= 1'b0;
            vs_prev_q     <= 1'b1;
            frame_tick_q  <= 1'b0;
            pixel_q       <= 8'd0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            house_q       <= house_d;
            house_valid_q <= house_valid_d;
            success_q     <= success_d;
            vs_prev_q     <= vs;
            frame_tick_q  <= vs_prev_q & ~vs;
            pixel_q       <= pixel_d;
        end
    end

    assign pixel_index = pixel_q;
    assign state       = state_q;
    assign house       = house_q;
    assign house_valid = house_valid_q;
    assign success     = success_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: flow timing, house latch, trace outcomes,
// pixel arbitration and synchronous reset.
module tb_screen_sequencer;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        vs;
    logic [3:0]  house_btn;
    logic [15:0] ir_in;
    logic        in_trace, crest_here, cursor_here, traced_here, fade_here;
    logic [7:0]  logo_idx, crest_idx, cursor_idx, box_idx, fade_idx, bg_idx;
    logic [7:0]  pixel_index;
    logic [1:0]  state;
    logic [1:0]  house;
    logic        house_valid;
    logic        success;
    logic        frame_tick;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 vga_clk = ~vga_clk;

    screen_sequencer #(
        .LOGO_FRAMES (2),
        .TRACE_FRAMES(2),
        .FADE_FRAMES (3),
        .TARGET_MASK (16'hFFFF)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .vs         (vs),
        .house_btn  (house_btn),
        .ir_in      (ir_in),
        .in_trace   (in_trace),
        .crest_here (crest_here),
        .cursor_here(cursor_here),
        .traced_here(traced_here),
        .fade_here  (fade_here),
        .logo_idx   (logo_idx),
        .crest_idx  (crest_idx),
        .cursor_idx (cursor_idx),
        .box_idx    (box_idx),
        .fade_idx   (fade_idx),
        .bg_idx     (bg_idx),
        .pixel_index(pixel_index),
        .state      (state),
        .house      (house),
        .house_valid(house_valid),
        .success    (success),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // vs low for one cycle: tick visible after the 1st step, acted on at the 2nd.
    task automatic vs_pulse();
        vs = 1'b0;
        step();
        vs = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b1; vs = 1'b1; house_btn = 4'd0; ir_in = 16'd0;
        in_trace = 1'b0; crest_here = 1'b0; cursor_here = 1'b0;
        traced_here = 1'b0; fade_here = 1'b0;
        logo_idx = 8'h11; crest_idx = 8'hAA; cursor_idx = 8'h22;
        box_idx = 8'h33; fade_idx = 8'h44; bg_idx = 8'h05;

        // 1. Reset and LOGO timing
        idle(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pixel", 32'(pixel_index), 32'd0);
        chk("rst_house", 32'(house), 32'd0);
        chk("rst_hvalid", 32'(house_valid), 32'd0);
        chk("rst_success", 32'(success), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        reset = 1'b0;
        step();
        chk("logo_bg", 32'(pixel_index), 32'h05);
        chk("no_spurious_tick", 32'(frame_tick), 32'd0);
        in_trace = 1'b1;
        step();
        chk("logo_idx", 32'(pixel_index), 32'h11);
        in_trace = 1'b0;
        idle(5);
        vs = 1'b0;
        step();
        chk("tick1_pulse", 32'(frame_tick), 32'd1);
        vs = 1'b1;
        step();
        chk("tick1_gone", 32'(frame_tick), 32'd0);
        chk("logo_fcnt1", 32'(dut.fcnt_q), 32'd1);
        chk("logo_hold", 32'(state), 32'd0);
        idle(5);
        vs = 1'b0;
        step();
        chk("logo_tick2_still", 32'(state), 32'd0);
        vs = 1'b1;
        step();
        chk("logo_to_select", 32'(state), 32'd1);
        chk("select_fcnt0", 32'(dut.fcnt_q), 32'd0);

        // 2. House selection
        crest_here = 1'b1;
        step();
        chk("select_crest", 32'(pixel_index), 32'hAA);
        crest_here = 1'b0;
        house_btn = 4'b0110;
        step();
        chk("two_hot_ignored", 32'(state), 32'd1);
        chk("two_hot_hvalid", 32'(house_valid), 32'd0);
        house_btn = 4'b0100;
        step();
        chk("sel_state", 32'(state), 32'd2);
        chk("sel_house", 32'(house), 32'd2);
        chk("sel_hvalid", 32'(house_valid), 32'd1);
        house_btn = 4'b0000;

        // 3. Trace success and fade
        ir_in = 16'h0000;
        step();
        chk("trace_wait0", 32'(state), 32'd2);
        ir_in = 16'h00FF;
        step();
        chk("trace_wait1", 32'(state), 32'd2);
        ir_in = 16'hFFFF;
        step();
        chk("trace_done_state", 32'(state), 32'd3);
        chk("trace_done_success", 32'(success), 32'd1);
        ir_in = 16'h0000;
        fade_here = 1'b1;
        step();
        chk("fade_idx", 32'(pixel_index), 32'h44);
        fade_here = 1'b0;
        vs_pulse();
        vs_pulse();
        chk("fade_hold", 32'(state), 32'd3);
        vs_pulse();
        chk("fade_to_select", 32'(state), 32'd1);
        chk("fade_hvalid_clr", 32'(house_valid), 32'd0);
        chk("fade_house_held", 32'(house), 32'd2);
        chk("fade_success_held", 32'(success), 32'd1);

        // 5. Arbitration in TRACE (entered with gryffindor)
        house_btn = 4'b0001;
        step();
        house_btn = 4'b0000;
        chk("g_state", 32'(state), 32'd2);
        chk("g_house", 32'(house), 32'd0);
        chk("trace_entry_success_clr", 32'(success), 32'd0);
        in_trace = 1'b1; cursor_here = 1'b1; traced_here = 1'b1;
        step();
        chk("arb_cursor", 32'(pixel_index), 32'h22);
        cursor_here = 1'b0;
        step();
        chk("arb_box", 32'(pixel_index), 32'h33);
        traced_here = 1'b0;
        step();
        chk("arb_zero", 32'(pixel_index), 32'h00);
        crest_here = 1'b1;
        step();
        chk("arb_crest", 32'(pixel_index), 32'hAA);
        crest_here = 1'b0; in_trace = 1'b0;
        step();
        chk("arb_bg", 32'(pixel_index), 32'h05);

        // 4. Timeout, then tie on the timeout tick
        ir_in = 16'h00FF;
        vs_pulse();
        chk("timeout_hold", 32'(state), 32'd2);
        vs_pulse();
        chk("timeout_state", 32'(state), 32'd3);
        chk("timeout_success", 32'(success), 32'd0);
        ir_in = 16'h0000;
        vs_pulse(); vs_pulse(); vs_pulse();
        chk("timeout_fade_done", 32'(state), 32'd1);
        house_btn = 4'b1000;
        step();
        house_btn = 4'b0000;
        chk("r_house", 32'(house), 32'd3);
        vs_pulse();
        vs = 1'b0;
        step();
        vs = 1'b1;
        ir_in = 16'hFFFF;
        step();
        chk("tie_state", 32'(state), 32'd3);
        chk("tie_success", 32'(success), 32'd1);
        ir_in = 16'h0000;

        // Button held through FADE -> SELECT latches on the first SELECT cycle
        vs_pulse(); vs_pulse();
        house_btn = 4'b0010;
        vs_pulse();
        chk("held_select", 32'(state), 32'd1);
        step();
        chk("held_trace", 32'(state), 32'd2);
        chk("held_house", 32'(house), 32'd1);
        house_btn = 4'b0000;

        // 6. Reset mid-TRACE
        step();
        chk("pre_rst_pixel", 32'(pixel_index), 32'h05);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_fcnt", 32'(dut.fcnt_q), 32'd0);
        chk("mid_rst_hvalid", 32'(house_valid), 32'd0);
        chk("mid_rst_pixel", 32'(pixel_index), 32'd0);
        chk("mid_rst_house", 32'(house), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
